mult_accum_multi: RTL and testbench

MULT_ACCUM_MULTI -- requirements
Module: mult_accum_multi

---
 rtl/mult_accum_multi.sv | 353 +++++++++++++++++++++++++++++++++++
 tb/tb_mult_accum_multi.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_accum_multi.sv
// Multi-channel multiply-accumulate: acc[ch] = {acc +/- a*b | +/- a*b}, NUM_CH independent channels.
// Latency: op accepted at edge t lands in its channel at edge t+2; readout strobes one cycle after request.
// Backpressure: in_ready drops only while a clear_all sequence drains the pipe and zeroes the channels.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         operation handshake; in_ch, in_a, in_b, in_signed, in_sub, in_load
//   clear_all                 zero every channel (honoured in IDLE only)
//   rd_req, rd_ch             readout request; rd_valid, rd_data, rd_ovf the one-cycle result
//   busy                      clear sequence in progress
// Build option: define MULT_ACCUM_SAT_EN for saturating arithmetic with per-channel sticky
// overflow bits; without it arithmetic wraps and rd_ovf is tied low.
// ACC_W must be at least 2*DATA_W so a full product always fits in the accumulator.
module mult_accum_multi #(
    parameter int  DATA_W = 16,
    parameter int  ACC_W  = 32,
    parameter int  NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_signed,
    input  logic              in_sub,
    input  logic              in_load,
    input  logic              clear_all,
    input  logic              rd_req,
    input  logic [CH_W-1:0]   rd_ch,
    output logic              rd_valid,
    output logic [ACC_W-1:0]  rd_data,
    output logic              rd_ovf,
    output logic              busy
);

    localparam int PROD_W = 2 * DATA_W;
`ifdef MULT_ACCUM_SAT_EN
    // Two guard bits: enough headroom for acc +/- product in either signedness.
    localparam int ARITH_W = ACC_W + 2;
    localparam logic signed [ARITH_W-1:0] SMAX = {3'b000, {(ACC_W-1){1'b1}}};
    localparam logic signed [ARITH_W-1:0] SMIN = {3'b111, {(ACC_W-1){1'b0}}};
    localparam logic signed [ARITH_W-1:0] UMAX = {2'b00, {ACC_W{1'b1}}};
`else
    localparam int ARITH_W = ACC_W;
`endif
    localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // Non-power-of-two channel counts leave unused encodings of in_ch/rd_ch.
    function automatic logic ch_in_range(input logic [CH_W-1:0] ch);
        return (32'(ch) < NUM_CH);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [CH_W-1:0]     clr_idx_q, clr_idx_d;
    logic                live_q;            // low while in reset, high from the first edge after

    logic                s1_vld_q, s1_vld_d;
    logic [CH_W-1:0]     s1_ch_q, s1_ch_d;
    logic [PROD_W-1:0]   s1_prod_q, s1_prod_d;
    logic                s1_sgn_q, s1_sgn_d;
    logic                s1_sub_q, s1_sub_d;
    logic                s1_load_q, s1_load_d;

    logic                s2_vld_q, s2_vld_d;
    logic [CH_W-1:0]     s2_ch_q, s2_ch_d;
    logic signed [ARITH_W-1:0] s2_ext_q, s2_ext_d;
    logic                s2_sgn_q, s2_sgn_d;
    logic                s2_sub_q, s2_sub_d;
    logic                s2_load_q, s2_load_d;

    logic [ACC_W-1:0]    acc_q [NUM_CH];
    logic [ACC_W-1:0]    acc_d [NUM_CH];

    logic                rd_vld_q, rd_vld_d;
    logic [ACC_W-1:0]    rd_data_q, rd_data_d;

    logic                accept;
    logic [PROD_W-1:0]   op_a_x, op_b_x, prod;

    logic signed [ARITH_W-1:0] cur_x, res_x;
    logic [ACC_W-1:0]    upd_val;

    // ------------------------------------------------------------------
    // Control FSM: IDLE accepts ops; DRAIN waits for the pipe to empty;
    // CLEAR zeroes one channel per cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = live_q;
                if (clear_all) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                // Nothing is accepted here, so once stage 1 is empty the stage-2
                // write (if any) completes on this edge and the pipe is empty after it.
                if (!s1_vld_q) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end
            end
            ST_CLEAR: begin
                busy = 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = ST_IDLE;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Stage 1: multiply. Both operands are extended to the product width
    // so a single unsigned multiplier yields the correct low 2*DATA_W bits
    // for either signedness.
    // ------------------------------------------------------------------
    always_comb begin
        if (in_signed) begin
            op_a_x = {{DATA_W{in_a[DATA_W-1]}}, in_a};
            op_b_x = {{DATA_W{in_b[DATA_W-1]}}, in_b};
        end else begin
            op_a_x = {{DATA_W{1'b0}}, in_a};
            op_b_x = {{DATA_W{1'b0}}, in_b};
        end
        prod = op_a_x * op_b_x;
    end

    always_comb begin
        // Out-of-range channels are accepted but never enter the pipe.
        s1_vld_d  = accept && ch_in_range(in_ch);
        s1_ch_d   = s1_ch_q;
        s1_prod_d = s1_prod_q;
        s1_sgn_d  = s1_sgn_q;
        s1_sub_d  = s1_sub_q;
        s1_load_d = s1_load_q;
        if (s1_vld_d) begin
            s1_ch_d   = in_ch;
            s1_prod_d = prod;
            s1_sgn_d  = in_signed;
            s1_sub_d  = in_sub;
            s1_load_d = in_load;
        end

        // Stage 2 register: product extended to the arithmetic width.
        s2_vld_d  = s1_vld_q;
        s2_ch_d   = s2_ch_q;
        s2_ext_d  = s2_ext_q;
        s2_sgn_d  = s2_sgn_q;
        s2_sub_d  = s2_sub_q;
        s2_load_d = s2_load_q;
        if (s1_vld_q) begin
            s2_ch_d   = s1_ch_q;
            s2_sgn_d  = s1_sgn_q;
            s2_sub_d  = s1_sub_q;
            s2_load_d = s1_load_q;
            if (s1_sgn_q) begin
                s2_ext_d = ARITH_W'($signed(s1_prod_q));
            end else begin
                s2_ext_d = ARITH_W'(s1_prod_q);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: read-modify-write of the target channel in a single cycle,
    // so back-to-back ops to one channel need no forwarding.
    // ------------------------------------------------------------------
`ifdef MULT_ACCUM_SAT_EN
    logic upd_clamp;
`endif

    always_comb begin
        if (s2_sgn_q) begin
            cur_x = ARITH_W'($signed(acc_q[s2_ch_q]));
        end else begin
            cur_x = ARITH_W'(acc_q[s2_ch_q]);
        end

        if (s2_load_q) begin
            res_x = s2_sub_q ? -s2_ext_q : s2_ext_q;
        end else begin
            res_x = s2_sub_q ? (cur_x - s2_ext_q) : (cur_x + s2_ext_q);
        end

        upd_val = res_x[ACC_W-1:0];
`ifdef MULT_ACCUM_SAT_EN
        upd_clamp = 1'b0;
        if (s2_sgn_q) begin
            if (res_x > SMAX) begin
                upd_val   = SMAX[ACC_W-1:0];
                upd_clamp = 1'b1;
            end else if (res_x < SMIN) begin
                upd_val   = SMIN[ACC_W-1:0];
                upd_clamp = 1'b1;
            end
        end else begin
            if (res_x > UMAX) begin
                upd_val   = UMAX[ACC_W-1:0];
                upd_clamp = 1'b1;
            end else if (res_x[ARITH_W-1]) begin
                upd_val   = '0;
                upd_clamp = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i] = acc_q[i];
        end
        if (s2_vld_q) begin
            acc_d[s2_ch_q] = upd_val;
        end
        // The pipe is always empty in CLEAR, so the two writes never collide.
        if (state_q == ST_CLEAR) begin
            acc_d[clr_idx_q] = '0;
        end
    end

    // ------------------------------------------------------------------
    // Readout: returns the channel value as it stands after this edge,
    // hence taken from the next-state array (includes the stage-2 write).
    // ------------------------------------------------------------------
    always_comb begin
        rd_vld_d  = rd_req;
        rd_data_d = rd_data_q;
        if (rd_req) begin
            if (ch_in_range(rd_ch)) begin
                rd_data_d = acc_d[rd_ch];
            end else begin
                rd_data_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            clr_idx_q <= '0;
            live_q    <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_ch_q   <= '0;
            s1_prod_q <= '0;
            s1_sgn_q  <= 1'b0;
            s1_sub_q  <= 1'b0;
            s1_load_q <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_ch_q   <= '0;
            s2_ext_q  <= '0;
            s2_sgn_q  <= 1'b0;
            s2_sub_q  <= 1'b0;
            s2_load_q <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            live_q    <= 1'b1;
            s1_vld_q  <= s1_vld_d;
            s1_ch_q   <= s1_ch_d;
            s1_prod_q <= s1_prod_d;
            s1_sgn_q  <= s1_sgn_d;
            s1_sub_q  <= s1_sub_d;
            s1_load_q <= s1_load_d;
            s2_vld_q  <= s2_vld_d;
            s2_ch_q   <= s2_ch_d;
            s2_ext_q  <= s2_ext_d;
            s2_sgn_q  <= s2_sgn_d;
            s2_sub_q  <= s2_sub_d;
            s2_load_q <= s2_load_d;
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign rd_valid = rd_vld_q;
    assign rd_data  = rd_data_q;

`ifdef MULT_ACCUM_SAT_EN
    // Sticky overflow per channel: set by any clamped update, cleared by
    // reset, the clear sequence, or a load (which may itself set it again).
    logic ovf_q [NUM_CH];
    logic ovf_d [NUM_CH];
    logic rd_ovf_q, rd_ovf_d;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ovf_d[i] = ovf_q[i];
        end
        if (s2_vld_q) begin
            ovf_d[s2_ch_q] = (s2_load_q ? 1'b0 : ovf_q[s2_ch_q]) | upd_clamp;
        end
        if (state_q == ST_CLEAR) begin
            ovf_d[clr_idx_q] = 1'b0;
        end
        rd_ovf_d = rd_ovf_q;
        if (rd_req) begin
            rd_ovf_d = ch_in_range(rd_ch) ? ovf_d[rd_ch] : 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ovf_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                ovf_q[i] <= 1'b0;
            end
        end else begin
            rd_ovf_q <= rd_ovf_d;
            for (int i = 0; i < NUM_CH; i++) begin
                ovf_q[i] <= ovf_d[i];
            end
        end
    end

    assign rd_ovf = rd_ovf_q;
`else
    assign rd_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mult_accum_multi.sv
// Self-checking bench for mult_accum_multi: directed scenarios plus randomized traffic
// checked against a behavioural model (per-channel values, ops landing two edges after acceptance).
// A second 3-channel instance exercises out-of-range channel handling.
`timescale 1ns/1ps
module tb_mult_accum_multi;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              in_valid, in_ready, in_signed, in_sub, in_load, clear_all;
    logic [CH_W-1:0]   in_ch, rd_ch;
    logic [DATA_W-1:0] in_a, in_b;
    logic              rd_req, rd_valid, rd_ovf, busy;
    logic [ACC_W-1:0]  rd_data;

    mult_accum_multi #(.DATA_W(DATA_W), .ACC_W(ACC_W), .NUM_CH(NUM_CH)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_sub(in_sub), .in_load(in_load),
        .clear_all(clear_all), .rd_req(rd_req), .rd_ch(rd_ch),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ovf(rd_ovf), .busy(busy)
    );

    // 3-channel instance: encoding 3 of the 2-bit channel field is out of range.
    logic              in_valid3, in_ready3, rd_req3, rd_valid3, rd_ovf3, busy3;
    logic [1:0]        in_ch3, rd_ch3;
    logic [DATA_W-1:0] in_a3, in_b3;
    logic [ACC_W-1:0]  rd_data3;

    mult_accum_multi #(.DATA_W(DATA_W), .ACC_W(ACC_W), .NUM_CH(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_ch(in_ch3),
        .in_a(in_a3), .in_b(in_b3), .in_signed(1'b0), .in_sub(1'b0), .in_load(1'b1),
        .clear_all(1'b0), .rd_req(rd_req3), .rd_ch(rd_ch3),
        .rd_valid(rd_valid3), .rd_data(rd_data3), .rd_ovf(rd_ovf3), .busy(busy3)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          land;
        int          ch;
        logic [15:0] a;
        logic [15:0] b;
        bit          sgn;
        bit          sub;
        bit          load;
    } op_t;

    logic [ACC_W-1:0] m_acc [NUM_CH];
    bit               m_ovf [NUM_CH];
    op_t              pq [$];
    int               cyc = 0;
    logic [ACC_W-1:0] last_rd = '0;
    bit               last_ovf = 1'b0;

    function automatic void model_zero();
        for (int i = 0; i < NUM_CH; i++) begin
            m_acc[i] = '0;
            m_ovf[i] = 1'b0;
        end
    endfunction

    function automatic void apply(input op_t o);
        longint p, cur, r;
        bit clamp;
        clamp = 1'b0;
        if (o.sgn) p = longint'($signed(o.a)) * longint'($signed(o.b));
        else       p = longint'(o.a) * longint'(o.b);
        if (o.sgn) cur = longint'($signed(m_acc[o.ch]));
        else       cur = longint'(m_acc[o.ch]);
        if (o.load) r = o.sub ? -p : p;
        else        r = o.sub ? cur - p : cur + p;
`ifdef MULT_ACCUM_SAT_EN
        if (o.sgn) begin
            if (r > 64'sh7FFF_FFFF) begin r = 64'sh7FFF_FFFF; clamp = 1'b1; end
            else if (r < -64'sh8000_0000) begin r = -64'sh8000_0000; clamp = 1'b1; end
        end else begin
            if (r > 64'shFFFF_FFFF) begin r = 64'shFFFF_FFFF; clamp = 1'b1; end
            else if (r < 0) begin r = 0; clamp = 1'b1; end
        end
`endif
        m_acc[o.ch] = r[31:0];
        m_ovf[o.ch] = (o.load ? 1'b0 : m_ovf[o.ch]) | clamp;
    endfunction

    // One clock: capture what the DUT samples, advance the model, check the readout.
    task automatic tick();
        bit   acc_now, rd_now;
        int   rch;
        op_t  o;
        acc_now = in_valid && in_ready;
        rd_now  = rd_req;
        rch     = int'(rd_ch);
        o.ch = int'(in_ch); o.a = in_a; o.b = in_b;
        o.sgn = in_signed; o.sub = in_sub; o.load = in_load;
        @(posedge clk);
        cyc++;
        if (acc_now) begin
            o.land = cyc + 2;
            pq.push_back(o);
        end
        while (pq.size() > 0 && pq[0].land == cyc) apply(pq.pop_front());
        #1;
        if (rd_now) begin
            last_rd  = m_acc[rch];
            last_ovf = m_ovf[rch];
            check("rd_valid_pulse", rd_valid, 1'b1);
        end else begin
            check("rd_valid_idle", rd_valid, 1'b0);
        end
        check("rd_data", rd_data, last_rd);
        check("rd_ovf", rd_ovf, last_ovf);
    endtask

    task automatic idle();
        in_valid = 1'b0; in_load = 1'b0; in_sub = 1'b0; in_signed = 1'b0;
        clear_all = 1'b0; rd_req = 1'b0;
    endtask

    task automatic set_op(input int ch, input logic [15:0] a, input logic [15:0] b,
                          input bit sgn, input bit sub, input bit load);
        in_valid = 1'b1; in_ch = CH_W'(ch); in_a = a; in_b = b;
        in_signed = sgn; in_sub = sub; in_load = load;
    endtask

    task automatic rd(input int ch);
        rd_req = 1'b1; rd_ch = CH_W'(ch);
        tick();
        rd_req = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_ovf", rd_ovf, 1'b0);
        model_zero();
        pq.delete();
        last_rd = '0; last_ovf = 1'b0;
        @(posedge clk); cyc++; #1;
        check("rst_ready_held", in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); cyc++; #1;
        check("rst_ready_back", in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int busy_cnt;
        logic [ACC_W-1:0] exp048;
        bit exp048_ovf;

        rst = 1'b1;
        in_ch = '0; rd_ch = '0; in_a = '0; in_b = '0;
        in_valid3 = 1'b0; rd_req3 = 1'b0; in_ch3 = '0; rd_ch3 = '0; in_a3 = '0; in_b3 = '0;
        do_reset();

        // Two back-to-back ops on ch1: 3*4 then (-2)*5 signed -> 2
        set_op(1, 16'd3, 16'd4, 1'b0, 1'b0, 1'b0); tick();
        set_op(1, 16'hFFFE, 16'd5, 1'b1, 1'b0, 1'b0); tick();
        idle(); tick();
        rd(1);
        check("b2b_ch1", rd_data, 2);

        // Alternating ch0 += 1*1, ch2 -= 2*2, eight cycles
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) set_op(0, 16'd1, 16'd1, 1'b1, 1'b0, 1'b0);
            else            set_op(2, 16'd2, 16'd2, 1'b1, 1'b1, 1'b0);
            tick();
        end
        idle(); tick(); tick();
        rd(0); check("alt_ch0", rd_data, 4);
        rd(2); check("alt_ch2", rd_data, 32'hFFFF_FFF0);

        // Unsigned 0xFFFF*0xFFFF twice on ch0 (load then add)
        set_op(0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1); tick();
        set_op(0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0); tick();
        idle(); tick();
        rd(0);
`ifdef MULT_ACCUM_SAT_EN
        exp048 = 32'hFFFF_FFFF; exp048_ovf = 1'b1;
`else
        exp048 = 32'hFFFC_0002; exp048_ovf = 1'b0;
`endif
        check("big_sq_data", rd_data, exp048);
        check("big_sq_ovf", rd_ovf, exp048_ovf);

        // Readout coinciding with the stage-2 write of +7 to a zeroed ch1
        set_op(1, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1); tick();
        idle(); tick();
        set_op(1, 16'd7, 16'd1, 1'b0, 1'b0, 1'b0); tick();
        idle(); tick();
        rd(1);
        check("rd_bypass_vld", rd_valid, 1'b1);
        check("rd_bypass_data", rd_data, 7);
        tick();
        check("rd_hold_vld", rd_valid, 1'b0);
        check("rd_hold_data", rd_data, 7);

        // ch3 loaded with 100, then clear_all together with +5 on ch3
        set_op(3, 16'd10, 16'd10, 1'b0, 1'b0, 1'b1); tick();
        idle(); tick(); tick();
        rd(3); check("ch3_loaded", rd_data, 100);
        set_op(3, 16'd5, 16'd1, 1'b0, 1'b0, 1'b0);
        clear_all = 1'b1;
        tick();
        idle();
        busy_cnt = 0;
        for (int k = 0; k < 40 && busy; k++) begin
            check("clr_ready_low", in_ready, 1'b0);
            busy_cnt++;
            // Readout during the drain sees the +5 landing (100 -> 105).
            rd_req = (busy_cnt == 2); rd_ch = 2'd3;
            tick();
            rd_req = 1'b0;
        end
        check("clr_busy_cycles", busy_cnt, 2 + NUM_CH);
        check("clr_done", busy, 1'b0);
        model_zero();
        for (int c = 0; c < NUM_CH; c++) begin
            rd(c);
            check("clr_zero", rd_data, 0);
        end

        // Out-of-range channel on the 3-channel instance
        in_valid3 = 1'b1; in_ch3 = 2'd0; in_a3 = 16'd9; in_b3 = 16'd1; tick();
        in_ch3 = 2'd3; in_a3 = 16'd5; in_b3 = 16'd5; tick();
        in_valid3 = 1'b0; tick(); tick();
        rd_req3 = 1'b1; rd_ch3 = 2'd3; tick();
        check("oor_rd_valid", rd_valid3, 1'b1);
        check("oor_rd_data", rd_data3, 0);
        rd_ch3 = 2'd0; tick();
        check("oor_ch0_intact", rd_data3, 9);
        rd_req3 = 1'b0; tick();
        check("oor_rd_valid_low", rd_valid3, 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            check("rand_ready", in_ready, 1'b1);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_ch     = CH_W'($urandom_range(0, NUM_CH - 1));
            if ($urandom_range(0, 1) == 0) begin
                in_a = 16'($urandom); in_b = 16'($urandom);
            end else begin
                in_a = 16'($urandom_range(0, 20)); in_b = 16'($urandom_range(0, 20));
            end
            in_signed = 1'($urandom);
            in_sub    = 1'($urandom);
            in_load   = ($urandom_range(0, 7) == 0);
            rd_req    = 1'($urandom);
            rd_ch     = CH_W'($urandom_range(0, NUM_CH - 1));
            tick();
        end
        idle(); tick(); tick();
        for (int c = 0; c < NUM_CH; c++) rd(c);

        // Reset during CLEAR
        set_op(1, 16'd3, 16'd3, 1'b0, 1'b0, 1'b1);
        clear_all = 1'b1;
        tick();
        idle(); tick(); tick();
        check("mid_clear_busy", busy, 1'b1);
        #2;
        do_reset();

        // Reset with an op sitting in stage 1
        set_op(2, 16'd11, 16'd11, 1'b0, 1'b0, 1'b1); tick();
        do_reset();
        idle(); tick(); tick(); tick();
        for (int c = 0; c < NUM_CH; c++) begin
            rd(c);
            check("post_rst_zero", rd_data, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
